// File: rtl/gfx_transform_pipe.sv
// gfx_transform_pipe: 3-stage 4x3 fixed-point affine transform feeding a per-id point bank.
// Define GFX_TRANSFORM_SAT_EN to saturate out-of-range results and report overflow_o.
module gfx_transform_pipe #(
  parameter int POINT_WIDTH    = 16,
  parameter int SUBPIXEL_WIDTH = 16,
  parameter int NUM_POINTS     = 3,
  parameter int ID_W           = $clog2(NUM_POINTS),
  localparam int W             = POINT_WIDTH + SUBPIXEL_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              valid_i,
  input  logic                              transform_i,
  input  logic [ID_W-1:0]                   point_id_i,
  input  logic [W-1:0]                      x_i,
  input  logic [W-1:0]                      y_i,
  input  logic [W-1:0]                      z_i,
  input  logic [W-1:0]                      aa,
  input  logic [W-1:0]                      ab,
  input  logic [W-1:0]                      ac,
  input  logic [W-1:0]                      tx,
  input  logic [W-1:0]                      ba,
  input  logic [W-1:0]                      bb,
  input  logic [W-1:0]                      bc,
  input  logic [W-1:0]                      ty,
  input  logic [W-1:0]                      ca,
  input  logic [W-1:0]                      cb,
  input  logic [W-1:0]                      cc,
  input  logic [W-1:0]                      tz,
  input  logic                              clear_i,
  output logic                              ready_o,
  output logic [NUM_POINTS*W-1:0]           px_o,
  output logic [NUM_POINTS*W-1:0]           py_o,
  output logic [NUM_POINTS*POINT_WIDTH-1:0] pz_o,
  output logic                              ack_o,
  output logic [ID_W-1:0]                   ack_id_o,
  output logic                              overflow_o,
  output logic                              err_o
);
  localparam int PW2 = 2 * W;
  localparam int SW  = 2 * W + 2;
  localparam logic signed [SW-1:0] HALF =
    {{(SW-SUBPIXEL_WIDTH){1'b0}}, 1'b1, {(SUBPIXEL_WIDTH-1){1'b0}}};

  logic ready_q, accept, id_ok;
  logic v1, v2, v3;
  logic t1, t2;
  logic [ID_W-1:0] id1, id2, id3;
  logic [W-1:0] coef [9];
  logic [W-1:0] trn [3];
  logic [W-1:0] pt [3];
  logic signed [PW2-1:0] prod1 [9];
  logic signed [PW2-1:0] trans1 [3];
  logic signed [SW-1:0] sum2 [3];
  logic signed [SW-1:0] sh [3];
  logic [W-1:0] fx1, fy1, fx2, fy2, x3, y3, rx, ry;
  logic [POINT_WIDTH-1:0] fz1, fz2, z3, rz;
  logic [W-1:0] bank_x [NUM_POINTS];
  logic [W-1:0] bank_y [NUM_POINTS];
  logic [POINT_WIDTH-1:0] bank_z [NUM_POINTS];
  logic unused_bits;

  assign coef    = '{aa, ab, ac, ba, bb, bc, ca, cb, cc};
  assign trn     = '{tx, ty, tz};
  assign pt      = '{x_i, y_i, z_i};
  assign ready_o = ready_q;
  assign accept  = valid_i & ready_q;
  assign id_ok   = (int'(id3) < NUM_POINTS);

  // Round half-up: add half an LSB of the output precision, then drop the extra fraction bits.
  always_comb begin
    for (int r = 0; r < 3; r++) sh[r] = (sum2[r] + HALF) >>> SUBPIXEL_WIDTH;
  end

`ifdef GFX_TRANSFORM_SAT_EN
  logic [2:0] out_rng, neg;
  logic rovf, ovf3, ovf_q;
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      neg[r]     = sh[r][SW-1];
      out_rng[r] = !(&sh[r][SW-1:W-1]) && (|sh[r][SW-1:W-1]);
    end
    rx   = out_rng[0] ? (neg[0] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sh[0][W-1:0];
    ry   = out_rng[1] ? (neg[1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sh[1][W-1:0];
    rz   = out_rng[2] ? (neg[2] ? {1'b1, {(POINT_WIDTH-1){1'b0}}} : {1'b0, {(POINT_WIDTH-1){1'b1}}})
                      : sh[2][W-1:SUBPIXEL_WIDTH];
    rovf = |out_rng;
  end
  assign unused_bits = ^sh[2][SUBPIXEL_WIDTH-1:0];
`else
  assign rx = sh[0][W-1:0];
  assign ry = sh[1][W-1:0];
  assign rz = sh[2][W-1:SUBPIXEL_WIDTH];
  assign unused_bits = ^{sh[0][SW-1:W], sh[1][SW-1:W], sh[2][SW-1:W], sh[2][SUBPIXEL_WIDTH-1:0]};
`endif

  // Datapath registers carry no reset; the stage valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      t1  <= transform_i;
      id1 <= point_id_i;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++)
          prod1[3*r+c] <= PW2'($signed(coef[3*r+c])) * PW2'($signed(pt[c]));
        trans1[r] <= PW2'($signed({trn[r], {SUBPIXEL_WIDTH{1'b0}}}));
      end
      fx1 <= x_i;
      fy1 <= y_i;
      fz1 <= z_i[W-1:SUBPIXEL_WIDTH];
    end
    if (v1) begin
      t2  <= t1;
      id2 <= id1;
      for (int r = 0; r < 3; r++)
        sum2[r] <= SW'(prod1[3*r]) + SW'(prod1[3*r+1]) + SW'(prod1[3*r+2]) + SW'(trans1[r]);
      fx2 <= fx1;
      fy2 <= fy1;
      fz2 <= fz1;
    end
    if (v2) begin
      id3 <= id2;
      x3  <= t2 ? rx : fx2;
      y3  <= t2 ? ry : fy2;
      z3  <= t2 ? rz : fz2;
`ifdef GFX_TRANSFORM_SAT_EN
      ovf3 <= t2 & rovf;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ready_q  <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      ack_o    <= 1'b0;
      ack_id_o <= '0;
      err_o    <= 1'b0;
      for (int k = 0; k < NUM_POINTS; k++) begin
        bank_x[k] <= '0;
        bank_y[k] <= '0;
        bank_z[k] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      v1      <= accept;
      v2      <= v1;
      v3      <= v2;
      ack_o   <= v3;
      if (v3) ack_id_o <= id3;
      err_o <= (err_o & ~clear_i) | (v3 & ~id_ok);
      for (int k = 0; k < NUM_POINTS; k++) begin
        if (v3 && id3 == ID_W'(k)) begin
          bank_x[k] <= x3;
          bank_y[k] <= y3;
          bank_z[k] <= z3;
        end
      end
    end
  end

`ifdef GFX_TRANSFORM_SAT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ovf_q <= 1'b0;
    else         ovf_q <= (ovf_q & ~clear_i) | (v3 & ovf3);
  end
  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

  for (genvar k = 0; k < NUM_POINTS; k++) begin : g_flat
    assign px_o[k*W +: W]                     = bank_x[k];
    assign py_o[k*W +: W]                     = bank_y[k];
    assign pz_o[k*POINT_WIDTH +: POINT_WIDTH] = bank_z[k];
  end
endmodule

// File: tb/tb_gfx_transform_pipe.sv
// Directed bench for gfx_transform_pipe: vector table plus hand sequences for pipelining,
// ordering, out-of-range ids, flag clearing and reset with points in flight.
module tb_gfx_transform_pipe;
  localparam int PW = 16;
  localparam int SP = 16;
  localparam int NP = 3;
  localparam int W  = PW + SP;
  localparam int IDW = 2;
`ifdef GFX_TRANSFORM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [31:0] ONE = 32'h0001_0000;

  typedef logic [11:0][31:0] mat_t;
  typedef struct {
    logic        t;
    logic [1:0]  id;
    logic [31:0] x, y, z;
    mat_t        m;
    logic [31:0] ex, ey;
    logic [15:0] ez;
    logic        eovf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ni, valid_i, transform_i, clear_i;
  logic [IDW-1:0] point_id_i;
  logic [W-1:0] x_i, y_i, z_i;
  logic [W-1:0] aa, ab, ac, tx, ba, bb, bc, ty, ca, cb, cc, tz;
  logic ready_o, ack_o, overflow_o, err_o;
  logic [IDW-1:0] ack_id_o;
  logic [NP*W-1:0] px_o, py_o;
  logic [NP*PW-1:0] pz_o;

  gfx_transform_pipe #(.POINT_WIDTH(PW), .SUBPIXEL_WIDTH(SP), .NUM_POINTS(NP)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .transform_i(transform_i),
    .point_id_i(point_id_i), .x_i(x_i), .y_i(y_i), .z_i(z_i),
    .aa(aa), .ab(ab), .ac(ac), .tx(tx), .ba(ba), .bb(bb), .bc(bc), .ty(ty),
    .ca(ca), .cb(cb), .cc(cc), .tz(tz), .clear_i(clear_i), .ready_o(ready_o),
    .px_o(px_o), .py_o(py_o), .pz_o(pz_o), .ack_o(ack_o), .ack_id_o(ack_id_o),
    .overflow_o(overflow_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_px [NP];
  logic [W-1:0]  exp_py [NP];
  logic [PW-1:0] exp_pz [NP];
  vec_t vecs [7];

  function automatic mat_t mk(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3,
                              input logic [31:0] c0, c1, c2, c3);
    mat_t m;
    m[0] = a0; m[1] = a1; m[2] = a2;  m[3] = a3;
    m[4] = b0; m[5] = b1; m[6] = b2;  m[7] = b3;
    m[8] = c0; m[9] = c1; m[10] = c2; m[11] = c3;
    return m;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_bank(input string tag);
    logic [NP*W-1:0] fx, fy;
    logic [NP*PW-1:0] fz;
    for (int k = 0; k < NP; k++) begin
      fx[k*W +: W]   = exp_px[k];
      fy[k*W +: W]   = exp_py[k];
      fz[k*PW +: PW] = exp_pz[k];
    end
    chk({tag, " bank px"}, 128'(px_o), 128'(fx));
    chk({tag, " bank py"}, 128'(py_o), 128'(fy));
    chk({tag, " bank pz"}, 128'(pz_o), 128'(fz));
  endtask

  task automatic set_coef(input mat_t m);
    aa = m[0]; ab = m[1]; ac = m[2];  tx = m[3];
    ba = m[4]; bb = m[5]; bc = m[6];  ty = m[7];
    ca = m[8]; cb = m[9]; cc = m[10]; tz = m[11];
  endtask

  task automatic put(input logic t, input logic [1:0] id, input logic [31:0] x, y, z);
    valid_i = 1'b1; transform_i = t; point_id_i = id; x_i = x; y_i = y; z_i = z;
  endtask

  task automatic model_zero;
    for (int k = 0; k < NP; k++) begin
      exp_px[k] = '0; exp_py[k] = '0; exp_pz[k] = '0;
    end
  endtask

  initial begin
    mat_t ident;
    ident = mk(ONE, 0, 0, 0, 0, ONE, 0, 0, 0, 0, ONE, 0);
    // {t, id, x, y, z, matrix, px, py, pz, overflow}
    vecs[0] = '{1'b1, 2'd0, 32'h0003_8000, 32'hFFFF_0000, 32'h0005_C000, ident,
                32'h0003_8000, 32'hFFFF_0000, 16'h0005, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 32'h0000_0001, 32'h0, 32'h0,
                mk(32'h0000_8000, 0, 0, 0, 0, ONE, 0, 0, 0, 0, ONE, 0),
                32'h0000_0001, 32'h0, 16'h0, 1'b0};
    vecs[2] = '{1'b0, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFE_8000, ident,
                32'h1234_5678, 32'h9ABC_DEF0, 16'hFFFE, 1'b0};
    vecs[3] = '{1'b1, 2'd0, 32'h0001_8000, 32'h0002_0000, 32'hFFFD_0000,
                mk(ONE, 32'h0002_0000, 0, 32'hFFFF_8000,
                   0, 32'hFFFF_0000, 32'h0000_4000, ONE,
                   0, 0, ONE, 32'h0002_0000),
                32'h0005_0000, 32'hFFFE_4000, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0002_8000,
                mk(32'h0000_8000, 0, 0, 0, 0, 32'h0000_8000, 0, 0, 0, 0, ONE, 0),
                32'h0, 32'h0000_0002, 16'h0002, 1'b0};
    vecs[5] = '{1'b1, 2'd2, 32'h0004_0000, 32'h0, 32'h0,
                mk(32'h4000_0000, 0, 0, 0, 0, ONE, 0, 0, 0, 0, ONE, 0),
                SAT ? 32'h7FFF_FFFF : 32'h0, 32'h0, 16'h0, SAT};
    vecs[6] = '{1'b1, 2'd0, 32'hFFFC_0000, 32'h0, 32'h0004_0000,
                mk(32'h4000_0000, 0, 0, 0, 0, ONE, 0, 0, 0, 0, 32'h4000_0000, 0),
                SAT ? 32'h8000_0000 : 32'h0, 32'h0, SAT ? 16'h7FFF : 16'h0, SAT};

    rst_ni = 1'b0; valid_i = 1'b0; transform_i = 1'b0; clear_i = 1'b0;
    point_id_i = '0; x_i = '0; y_i = '0; z_i = '0;
    set_coef(ident);
    model_zero();
    tick; tick;
    chk("reset ready", ready_o, 0);
    chk("reset ack", ack_o, 0);
    chk("reset ack_id", ack_id_o, 0);
    chk("reset overflow", overflow_o, 0);
    chk("reset err", err_o, 0);
    chk_bank("reset");
    rst_ni = 1'b1;
    tick;
    chk("ready after release", ready_o, 1);

    for (int i = 0; i < 7; i++) begin
      clear_i = 1'b1; tick; clear_i = 1'b0;
      set_coef(vecs[i].m);
      put(vecs[i].t, vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].z);
      tick;
      valid_i = 1'b0;
      tick; tick;
      chk($sformatf("v%0d no early ack", i), ack_o, 0);
      tick;
      chk($sformatf("v%0d ack", i), ack_o, 1);
      chk($sformatf("v%0d ack_id", i), ack_id_o, vecs[i].id);
      chk($sformatf("v%0d px", i), px_o[int'(vecs[i].id)*W +: W], vecs[i].ex);
      chk($sformatf("v%0d py", i), py_o[int'(vecs[i].id)*W +: W], vecs[i].ey);
      chk($sformatf("v%0d pz", i), pz_o[int'(vecs[i].id)*PW +: PW], vecs[i].ez);
      chk($sformatf("v%0d overflow", i), overflow_o, vecs[i].eovf);
      exp_px[vecs[i].id] = vecs[i].ex;
      exp_py[vecs[i].id] = vecs[i].ey;
      exp_pz[vecs[i].id] = vecs[i].ez;
    end
    chk_bank("table");
    tick; tick;
    chk("overflow sticky", overflow_o, SAT);
    clear_i = 1'b1; tick; clear_i = 1'b0;
    chk("overflow cleared", overflow_o, 0);

    // Back-to-back issue; coefficients change once the last point is accepted.
    set_coef(mk(32'h0002_0000, 0, 0, ONE, 0, 32'h0002_0000, 0, 0, 0, 0, 32'h0002_0000, 0));
    put(1'b1, 2'd0, 32'h0001_0000, 0, 0); tick;
    put(1'b1, 2'd1, 32'h0002_0000, 0, 0); tick;
    put(1'b1, 2'd2, 32'h0003_0000, 0, 0); tick;
    chk("burst no early ack", ack_o, 0);
    valid_i = 1'b0;
    set_coef(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("burst ack %0d", k), ack_o, 1);
      chk($sformatf("burst ack_id %0d", k), ack_id_o, k);
    end
    tick;
    chk("burst ack drops", ack_o, 0);
    exp_px[0] = 32'h0003_0000; exp_px[1] = 32'h0005_0000; exp_px[2] = 32'h0007_0000;
    for (int k = 0; k < 3; k++) begin
      exp_py[k] = '0; exp_pz[k] = '0;
    end
    chk_bank("burst");

    // Forward to id 1, then a transform to id 1 one cycle later overwrites it.
    set_coef(ident);
    put(1'b0, 2'd1, 32'hAAAA_0000, 32'h0000_5555, 32'hFFFE_8000); tick;
    put(1'b1, 2'd1, 32'h0001_0000, 32'h0002_0000, 32'h0007_0000); tick;
    valid_i = 1'b0;
    tick; tick;
    chk("fwd ack", ack_o, 1);
    chk("fwd ack_id", ack_id_o, 1);
    chk("fwd px", px_o[W +: W], 32'hAAAA_0000);
    chk("fwd pz", pz_o[PW +: PW], 16'hFFFE);
    tick;
    chk("overwrite ack", ack_o, 1);
    chk("overwrite ack_id", ack_id_o, 1);
    chk("overwrite pz", pz_o[PW +: PW], 16'h0007);
    exp_px[1] = 32'h0001_0000; exp_py[1] = 32'h0002_0000; exp_pz[1] = 16'h0007;
    chk_bank("overwrite");

    // Out-of-range id with clear_i asserted on the same edge that sets err_o.
    put(1'b1, 2'd3, 32'h0009_0000, 32'h0009_0000, 32'h0009_0000); tick;
    valid_i = 1'b0;
    tick; tick;
    clear_i = 1'b1;
    tick;
    clear_i = 1'b0;
    chk("bad id ack", ack_o, 1);
    chk("bad id ack_id", ack_id_o, 3);
    chk("bad id err set wins", err_o, 1);
    chk_bank("bad id");
    clear_i = 1'b1; tick; clear_i = 1'b0;
    chk("err cleared", err_o, 0);

    // Reset with two points in flight.
    put(1'b1, 2'd0, 32'h0005_0000, 0, 0); tick;
    put(1'b1, 2'd1, 32'h0006_0000, 0, 0); tick;
    valid_i = 1'b0;
    rst_ni = 1'b0;
    tick;
    chk("inflight reset ack", ack_o, 0);
    chk("inflight reset ready", ready_o, 0);
    model_zero();
    chk_bank("inflight reset");
    rst_ni = 1'b1;
    tick;
    chk("post reset ready", ready_o, 1);
    chk("post reset no ack", ack_o, 0);
    put(1'b1, 2'd2, 32'h0009_0000, 0, 32'h0001_0000); tick;
    valid_i = 1'b0;
    chk("discarded no ack", ack_o, 0);
    tick; tick;
    chk("post reset pt no early ack", ack_o, 0);
    tick;
    chk("post reset pt ack", ack_o, 1);
    chk("post reset pt ack_id", ack_id_o, 2);
    exp_px[2] = 32'h0009_0000; exp_pz[2] = 16'h0001;
    chk_bank("post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
